// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the load/store unit: widths, funct3 codes, FSM states.
package lsu_mem_stage_pkg;

    localparam int LSU_DATA_W = 64;
    localparam int LSU_BE_W   = LSU_DATA_W / 8;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_D  = 3'b011;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;
    localparam logic [2:0] LSU_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } lsu_state_e;

    function automatic logic f3_illegal(logic we, logic [2:0] f3);
        return we ? f3[2] : (f3 == 3'b111);
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] size_mask(logic [1:0] sz);
        logic [2:0] m;
        unique case (sz)
            2'b00:   m = 3'b000;
            2'b01:   m = 3'b001;
            2'b10:   m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Byte-lane generation, store lane shift and load extract/extend.
module lsu_data_align
    import lsu_mem_stage_pkg::*;
#(
    parameter int DATA_W = LSU_DATA_W,
    parameter int BE_W   = LSU_BE_W
) (
    input  logic [2:0]        funct3,
    input  logic [2:0]        off,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] wdata_sh,
    output logic [DATA_W-1:0] rdata_ext
);

    logic [DATA_W-1:0] rd_sh;
    logic [5:0]        bit_off;

    always_comb begin
        bit_off  = {off, 3'b000};
        wdata_sh = wdata << bit_off;
        rd_sh    = rdata >> bit_off;

        unique case (funct3[1:0])
            2'b00:   be = BE_W'(1) << off;
            2'b01:   be = BE_W'(3) << off;
            2'b10:   be = BE_W'(15) << off;
            default: be = '1;
        endcase

        unique case (funct3)
            LSU_B:   rdata_ext = {{(DATA_W-8){rd_sh[7]}}, rd_sh[7:0]};
            LSU_H:   rdata_ext = {{(DATA_W-16){rd_sh[15]}}, rd_sh[15:0]};
            LSU_W:   rdata_ext = {{(DATA_W-32){rd_sh[31]}}, rd_sh[31:0]};
            LSU_BU:  rdata_ext = {{(DATA_W-8){1'b0}}, rd_sh[7:0]};
            LSU_HU:  rdata_ext = {{(DATA_W-16){1'b0}}, rd_sh[15:0]};
            LSU_WU:  rdata_ext = {{(DATA_W-32){1'b0}}, rd_sh[31:0]};
            default: rdata_ext = rd_sh;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store unit FSM driving a req/gnt/rvalid data-memory port.
// LSU_MISALIGN_EXC_EN: misaligned accesses raise lsu_err instead of being masked.
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int DATA_W = LSU_DATA_W,
    parameter int BE_W   = LSU_BE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic              lsu_we,
    input  logic [2:0]        lsu_funct3,
    input  logic [DATA_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_done,
    output logic              lsu_err,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [BE_W-1:0]   dmem_be,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata
);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              req_q, req_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0] rdata_ext;
    logic [2:0]        amask;
    logic              bad;

    lsu_data_align #(
        .DATA_W (DATA_W),
        .BE_W   (BE_W)
    ) u_align (
        .funct3    (f3_q),
        .off       (addr_q[2:0]),
        .wdata     (wdata_q),
        .rdata     (dmem_rdata),
        .be        (be),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        amask   = size_mask(lsu_funct3[1:0]);
        bad     = f3_illegal(lsu_we, lsu_funct3);
`ifdef LSU_MISALIGN_EXC_EN
        bad     = bad | (|(lsu_addr[2:0] & amask));
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (lsu_valid) begin
                    we_d    = lsu_we;
                    f3_d    = lsu_funct3;
                    wdata_d = lsu_wdata;
`ifdef LSU_MISALIGN_EXC_EN
                    addr_d  = lsu_addr;
`else
                    addr_d  = {lsu_addr[DATA_W-1:3],
                               lsu_addr[2:0] & ~amask};
`endif
                    state_d = bad ? ST_DONE : ST_REQ;
                    err_d   = bad;
                end
            end
            ST_REQ: begin
                if (dmem_gnt) begin
                    state_d = we_q ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dmem_rvalid) begin
                    rdata_d = rdata_ext;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake outputs are registered copies of the next state.
        ready_d = (state_d == ST_IDLE);
        req_d   = (state_d == ST_REQ);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b1;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            req_q   <= req_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign lsu_ready  = ready_q;
    assign lsu_done   = done_q;
    assign lsu_err    = err_q;
    assign lsu_rdata  = rdata_q;
    assign dmem_req   = req_q;
    assign dmem_we    = req_q & we_q;
    assign dmem_addr  = req_q ? {addr_q[DATA_W-1:3], 3'b000} : '0;
    assign dmem_be    = req_q ? be : '0;
    assign dmem_wdata = req_q ? wdata_sh : '0;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Table-driven and randomized bench for lsu_mem_stage with a memory responder.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_valid;
    logic        lsu_ready;
    logic        lsu_we;
    logic [2:0]  lsu_funct3;
    logic [63:0] lsu_addr;
    logic [63:0] lsu_wdata;
    logic [63:0] lsu_rdata;
    logic        lsu_done;
    logic        lsu_err;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [7:0]  dmem_be;
    logic [63:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [63:0] dmem_rdata;

    int nvec = 0;
    int nerr = 0;
    logic [63:0] model_rd = 64'h0;

    always #5 clk = ~clk;

    lsu_mem_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_we      (lsu_we),
        .lsu_funct3  (lsu_funct3),
        .lsu_addr    (lsu_addr),
        .lsu_wdata   (lsu_wdata),
        .lsu_rdata   (lsu_rdata),
        .lsu_done    (lsu_done),
        .lsu_err     (lsu_err),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] mrd;
        int          g;
        int          r;
        logic        e_err;
        logic        e_req;
        logic [63:0] e_addr;
        logic [7:0]  e_be;
        logic [63:0] e_wd;
        logic [63:0] e_rd;
        int          e_lat;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!lsu_ready && n < 50) begin
            tick();
            n++;
        end
        chk("ready_before_op", {63'h0, lsu_ready}, 64'h1);
    endtask

    // Issue one request, answer it as memory, and report what was seen.
    task automatic run_op(
        input  logic        we,
        input  logic [2:0]  f3,
        input  logic [63:0] addr,
        input  logic [63:0] wdata,
        input  logic [63:0] mrd,
        input  int          g,
        input  int          r,
        output int          lat,
        output logic        err,
        output logic        req_seen,
        output logic [63:0] a_addr,
        output logic [7:0]  a_be,
        output logic        a_we,
        output logic [63:0] a_wd,
        output logic        stable,
        output logic [63:0] a_rd,
        output logic        one_shot
    );
        int reqc;
        int gcyc;
        wait_ready();
        lsu_valid  = 1'b1;
        lsu_we     = we;
        lsu_funct3 = f3;
        lsu_addr   = addr;
        lsu_wdata  = wdata;
        tick();
        lsu_valid  = 1'b0;
        lsu_we     = 1'($urandom);
        lsu_funct3 = 3'($urandom);
        lsu_addr   = {$urandom, $urandom};
        lsu_wdata  = {$urandom, $urandom};
        lat = -1; err = 1'b0; req_seen = 1'b0; stable = 1'b1;
        a_addr = '0; a_be = '0; a_we = 1'b0; a_wd = '0; a_rd = '0;
        reqc = 0; gcyc = -1;
        for (int c = 1; c <= 60; c++) begin
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            dmem_rdata  = {$urandom, $urandom};
            if (lsu_done) begin
                lat  = c;
                err  = lsu_err;
                a_rd = lsu_rdata;
                break;
            end
            if (dmem_req) begin
                if (!req_seen) begin
                    req_seen = 1'b1;
                    a_addr = dmem_addr;
                    a_be   = dmem_be;
                    a_we   = dmem_we;
                    a_wd   = dmem_wdata;
                end else if (a_addr !== dmem_addr || a_be !== dmem_be ||
                             a_we !== dmem_we || a_wd !== dmem_wdata) begin
                    stable = 1'b0;
                end
                if (reqc == g) begin
                    dmem_gnt    = 1'b1;
                    dmem_rvalid = 1'b1;
                    gcyc        = c;
                end
                reqc++;
            end
            if (gcyc >= 0 && c == gcyc + 1 + r && !we) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = mrd;
            end
            tick();
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        tick();
        one_shot = !lsu_done && lsu_ready;
    endtask

    // Reference behaviour from the size/offset rules, using plain arithmetic.
    task automatic model(
        input  logic        we,
        input  logic [2:0]  f3,
        input  logic [63:0] addr,
        input  logic [63:0] wdata,
        input  logic [63:0] mrd,
        input  int          g,
        input  int          r,
        output logic        e_err,
        output logic [63:0] e_addr,
        output logic [7:0]  e_be,
        output logic [63:0] e_wd,
        output int          e_lat
    );
        int size, off, eoff, nb;
        logic [63:0] v, mask;
        size  = 1 << f3[1:0];
        off   = int'(addr[2:0]);
        e_err = we ? (f3 > 3) : (f3 == 7);
`ifdef LSU_MISALIGN_EXC_EN
        if (off % size != 0) e_err = 1'b1;
`endif
        eoff   = off - (off % size);
        e_addr = addr & ~64'h7;
        e_be   = 8'(((1 << size) - 1) << eoff);
        e_wd   = wdata << (8 * eoff);
        if (!we && !e_err) begin
            v  = mrd >> (8 * eoff);
            nb = 8 * size;
            if (nb < 64) begin
                mask = (64'h1 << nb) - 64'h1;
                v = v & mask;
                if (f3 < 3 && v[nb-1]) v = v | ~mask;
            end
            model_rd = v;
        end
        e_lat = e_err ? 1 : (we ? 2 + g : 3 + g + r);
    endtask

    task automatic check_op(input string tag, input vec_t t);
        int lat;
        logic err, rs, awe, st, os;
        logic [63:0] aa, aw, ar;
        logic [7:0]  ab;
        run_op(t.we, t.f3, t.addr, t.wdata, t.mrd, t.g, t.r,
               lat, err, rs, aa, ab, awe, aw, st, ar, os);
        chk({tag, "_latency"}, 64'(lat), 64'(t.e_lat));
        chk({tag, "_err"}, {63'h0, err}, {63'h0, t.e_err});
        chk({tag, "_req"}, {63'h0, rs}, {63'h0, t.e_req});
        if (t.e_req) begin
            chk({tag, "_addr"}, aa, t.e_addr);
            chk({tag, "_be"}, {56'h0, ab}, {56'h0, t.e_be});
            chk({tag, "_we"}, {63'h0, awe}, {63'h0, t.we});
            chk({tag, "_stable"}, {63'h0, st}, 64'h1);
            if (t.we) chk({tag, "_wdata"}, aw, t.e_wd);
        end
        chk({tag, "_rdata"}, ar, t.e_rd);
        chk({tag, "_done_one_cycle"}, {63'h0, os}, 64'h1);
    endtask

    initial begin
        vec_t t;
        logic e_err;
        logic [63:0] e_addr, e_wd;
        logic [7:0]  e_be;
        int e_lat;
        logic nodone;

        tbl[0]  = '{0, 3'd0, 64'h1003, 64'h0, 64'h00000000_80000000, 0, 0,
                    0, 1, 64'h1000, 8'h08, 64'h0, 64'hFFFFFFFF_FFFFFF80, 3};
        tbl[1]  = '{0, 3'd6, 64'h2004, 64'h0, 64'h89ABCDEF_00000000, 0, 0,
                    0, 1, 64'h2000, 8'hF0, 64'h0, 64'h00000000_89ABCDEF, 3};
        tbl[2]  = '{1, 3'd1, 64'h3006, 64'h1234, 64'h0, 4, 0,
                    0, 1, 64'h3000, 8'hC0, 64'h1234_0000_0000_0000,
                    64'h00000000_89ABCDEF, 6};
`ifdef LSU_MISALIGN_EXC_EN
        tbl[3]  = '{1, 3'd2, 64'h4002, 64'hDEADBEEF, 64'h0, 0, 0,
                    1, 0, 64'h0, 8'h00, 64'h0, 64'h00000000_89ABCDEF, 1};
`else
        tbl[3]  = '{1, 3'd2, 64'h4002, 64'hDEADBEEF, 64'h0, 0, 0,
                    0, 1, 64'h4000, 8'h0F, 64'hDEADBEEF,
                    64'h00000000_89ABCDEF, 2};
`endif
        tbl[4]  = '{0, 3'd7, 64'h5000, 64'h0, 64'hFFFF, 0, 0,
                    1, 0, 64'h0, 8'h00, 64'h0, 64'h00000000_89ABCDEF, 1};
        tbl[5]  = '{0, 3'd3, 64'h6000, 64'h0, 64'h01234567_89ABCDEF, 1, 2,
                    0, 1, 64'h6000, 8'hFF, 64'h0, 64'h01234567_89ABCDEF, 6};
        tbl[6]  = '{0, 3'd1, 64'h7002, 64'h0, 64'h00000000_80010000, 0, 0,
                    0, 1, 64'h7000, 8'h0C, 64'h0, 64'hFFFFFFFF_FFFF8001, 3};
        tbl[7]  = '{0, 3'd5, 64'h7006, 64'h0, 64'hFFEE0000_00000000, 2, 1,
                    0, 1, 64'h7000, 8'hC0, 64'h0, 64'h00000000_0000FFEE, 6};
        tbl[8]  = '{0, 3'd4, 64'h8007, 64'h0, 64'hA5000000_00000000, 0, 0,
                    0, 1, 64'h8000, 8'h80, 64'h0, 64'h00000000_000000A5, 3};
        tbl[9]  = '{0, 3'd2, 64'h9000, 64'h0, 64'h00000000_F0000000, 0, 0,
                    0, 1, 64'h9000, 8'h0F, 64'h0, 64'hFFFFFFFF_F0000000, 3};
        tbl[10] = '{1, 3'd4, 64'h9100, 64'h55, 64'h0, 0, 0,
                    1, 0, 64'h0, 8'h00, 64'h0, 64'hFFFFFFFF_F0000000, 1};
        tbl[11] = '{1, 3'd3, 64'hA000, 64'h11223344_55667788, 64'h0, 0, 0,
                    0, 1, 64'hA000, 8'hFF, 64'h11223344_55667788,
                    64'hFFFFFFFF_F0000000, 2};
        tbl[12] = '{1, 3'd0, 64'hB005, 64'hAB, 64'h0, 1, 0,
                    0, 1, 64'hB000, 8'h20, 64'h0000AB00_00000000,
                    64'hFFFFFFFF_F0000000, 3};

        rst_n = 1'b0; lsu_valid = 1'b0; lsu_we = 1'b0; lsu_funct3 = '0;
        lsu_addr = '0; lsu_wdata = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_ready", {63'h0, lsu_ready}, 64'h1);
        chk("rst_req", {63'h0, dmem_req}, 64'h0);
        chk("rst_done", {63'h0, lsu_done}, 64'h0);
        chk("rst_err", {63'h0, lsu_err}, 64'h0);
        chk("rst_rdata", lsu_rdata, 64'h0);
        chk("rst_be", {56'h0, dmem_be}, 64'h0);

        for (int i = 0; i < 13; i++) begin
            check_op($sformatf("vec%0d", i), tbl[i]);
        end
        model_rd = tbl[12].e_rd;

        for (int i = 0; i < 40; i++) begin
            t.we    = 1'($urandom);
            t.f3    = 3'($urandom);
            t.addr  = {$urandom, $urandom};
            t.wdata = {$urandom, $urandom};
            t.mrd   = {$urandom, $urandom};
            t.g     = int'($urandom_range(0, 2));
            t.r     = int'($urandom_range(0, 2));
            model(t.we, t.f3, t.addr, t.wdata, t.mrd, t.g, t.r,
                  e_err, e_addr, e_be, e_wd, e_lat);
            t.e_err  = e_err;
            t.e_req  = !e_err;
            t.e_addr = e_addr;
            t.e_be   = e_be;
            t.e_wd   = e_wd;
            t.e_rd   = model_rd;
            t.e_lat  = e_lat;
            check_op($sformatf("rnd%0d", i), t);
        end

        // Reset while waiting for read data; the late rvalid must be dropped.
        wait_ready();
        lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'd3;
        lsu_addr = 64'h100; lsu_wdata = '0;
        tick();
        lsu_valid = 1'b0;
        chk("rw_req_up", {63'h0, dmem_req}, 64'h1);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rw_req_drop", {63'h0, dmem_req}, 64'h0);
        chk("rw_ready", {63'h0, lsu_ready}, 64'h1);
        chk("rw_rdata_clr", lsu_rdata, 64'h0);
        dmem_rvalid = 1'b1; dmem_rdata = 64'hCAFEBABE_DEADBEEF;
        nodone = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 1) dmem_rvalid = 1'b0;
            if (lsu_done || !lsu_ready) nodone = 1'b0;
        end
        chk("rw_no_done", {63'h0, nodone}, 64'h1);
        chk("rw_rdata_kept", lsu_rdata, 64'h0);

        // Reset while the request is still waiting for grant.
        lsu_valid = 1'b1; lsu_we = 1'b1; lsu_funct3 = 3'd0;
        lsu_addr = 64'h200; lsu_wdata = 64'h1;
        tick();
        lsu_valid = 1'b0;
        tick();
        chk("rq_req_up", {63'h0, dmem_req}, 64'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rq_req_drop", {63'h0, dmem_req}, 64'h0);
        chk("rq_be_zero", {56'h0, dmem_be}, 64'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit directly downstream of the ALU.
- Takes ALU result as effective address plus rs2 store data, and drives a 64-bit data-memory port with a req/gnt/rvalid handshake.
- Returns aligned, sign- or zero-extended load data for writeback.
- Multi-cycle: stalls the core via lsu_ready/lsu_done until memory completes.

Parameters:
- DATA_W, 64, datapath and address width (matches `DATA_W).
- BE_W, 8, byte-enable width (DATA_W/8).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- lsu_valid  in  1  request from core
- lsu_ready  out  1  LSU can accept; high only in IDLE
- lsu_we  in  1  1 = store, 0 = load
- lsu_funct3  in  3  RISC-V funct3 size/sign code
- lsu_addr  in  DATA_W  effective address (ALUOut)
- lsu_wdata  in  DATA_W  store data (rs2, low-justified)
- lsu_rdata  out  DATA_W  extended load result
- lsu_done  out  1  one-cycle completion pulse
- lsu_err  out  1  one-cycle error pulse, coincident with lsu_done
- dmem_req  out  1  memory request, held until grant
- dmem_we  out  1  write strobe
- dmem_addr  out  DATA_W  address with low 3 bits zeroed
- dmem_be  out  BE_W  byte lanes
- dmem_wdata  out  DATA_W  lane-shifted store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  DATA_W  read data, full doubleword

Behaviour:
- Reset: synchronous and active-low. All outputs are 0 except lsu_ready=1. State goes to IDLE. Reset mid-operation drops dmem_req the next cycle, and any later rvalid is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: lsu_ready=1. On lsu_valid, capture we, funct3, addr and wdata.
  - Illegal funct3: loads 3'b111; stores any value above 3'b011. Goes to DONE with err=1 and issues no memory access.
  - Misaligned access is handled per the optional feature below.
  - Otherwise goes to REQ.
- REQ: dmem_req=1, with dmem_* driven from captured registers and stable until gnt.
  - gnt and store: go to DONE.
  - gnt and load: go to WAIT.
  - rvalid in REQ is ignored; memory guarantees rvalid at least 1 cycle after gnt.
- WAIT: on rvalid, register the extracted load into lsu_rdata and go to DONE.
- DONE: lsu_done=1 for exactly one cycle, lsu_err as set, then IDLE. lsu_rdata holds until the next load completes; stores leave it unchanged.
- Latency (accept edge = cycle 0):
  - Error: done in cycle 1.
  - Store with immediate gnt: done in cycle 2.
  - Load with gnt in cycle 1 and rvalid in cycle 2: done in cycle 3.
- Byte lanes: off = addr[2:0].
  - B: be = 1<<off.
  - H: be = 3<<off.
  - W: be = 0x0F<<off.
  - D: be = 0xFF.
  - dmem_wdata = wdata << (8*off).
- Load extraction: (rdata >> 8*off), truncated to the size, then extended.
  - Sign extension: LB, LH, LW.
  - Zero extension: LBU, LHU, LWU; LD takes all 64 bits.
- Misaligned: off not a multiple of the access size.
- lsu_valid while not ready is ignored; the core must hold it.

Optional Feature:
- Macro: LSU_MISALIGN_EXC_EN.
- Defined: a misaligned access goes IDLE to DONE with lsu_err=1 and no dmem_req.
- Undefined: addr low bits are masked down to the natural alignment of the size, and the access proceeds normally with lsu_err=0.

Decomposition:
- Shared def.h: funct3 size codes (LSU_B, LSU_H, LSU_W, LSU_D, LSU_BU, LSU_HU, LSU_WU), FSM state encoding, `DATA_W and BE_W.
- One combinational sub-module, lsu_data_align: byte-enable generation, store lane shift, load extract and extend. The FSM stays in lsu_mem_stage.

Test Plan:
- LB addr=0x1003, dmem_rdata=0x00000000_80000000 → lsu_rdata=0xFFFFFFFF_FFFFFF80; dmem_addr=0x1000, be=0x08.
- LWU addr=0x2004, rdata=0x89ABCDEF_00000000 → lsu_rdata=0x00000000_89ABCDEF, done 3 cycles after accept.
- SH addr=0x3006, wdata=0x1234, gnt held low 4 cycles → req stays high with stable fields; be=0xC0, wdata=0x1234_0000_0000_0000; done 1 cycle after gnt.
- Misaligned SW addr=0x4002:
  - With LSU_MISALIGN_EXC_EN: done+err in cycle 1, no req.
  - Without it: req to 0x4000, be=0x0F.
- Load funct3=3'b111 → err=1, no req, lsu_rdata unchanged.
- rst_n low in WAIT, then late rvalid → no done, ready=1, rdata=0.
